multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle instruction sequencer for the 16-bit, 4-bit-opcode processor. It steps the shared datapath (single memory port, ALU, register file, PC) through FETCH/DECODE/EXEC/MEM/WB, one instruction at a time. It drives datapath strobes and waits on a variable-latency memory handshake. It also counts retired instructions and parks the core on HALT or on a memory timeout.

## Interface
- `MEM_TIMEOUT`, 16: maximum consecutive cycles a memory access may see `mem_ready` low (≥1).
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 4: IR[15:12]; valid from DECODE onward.
- `mem_ready` in 1: memory access completes this cycle.
- `branch_taken` in 1: ALU compare result for blt/bgt/beq, valid in EXEC.
- `mem_read`, `mem_write` out 1: memory strobes.
- `iord` out 1: memory address select (0 = PC, 1 = ALU result).
- `ir_write`, `mdr_write` out 1: IR and MDR load enables.
- `pc_write` out 1: PC load enable.
- `pc_src` out 2: PC source (00 = PC+2, 01 = branch target, 10 = jump target).
- `alu_op` out 2: ALU op class (00 = funct, 01 = compare, 10 = add).
- `alu_src` out 1: ALU B select (1 = immediate).
- `reg_write`, `reg_dst`, `mem_to_reg` out 1: register-file write controls.
- `halted` out 1: core parked.
- `mem_err` out 1: memory timeout occurred.
- `instret` out `CNT_W`: retired-instruction count.

## Operation
- Opcode map: 0000 type A, 1000 lw, 1011 sw, 0100 blt, 0101 bgt, 0110 beq, 1100 jmp, 1111 halt. All other opcodes execute as a NOP.
- States: RST, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR. The state register is 3 bits.
- RST: all outputs 0. Goes to FETCH unconditionally.
- FETCH: `mem_read`=1, `iord`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch `opcode` into `op_q`. All later decisions use `op_q`.
  - A/lw/sw/blt/bgt/beq go to EXEC.
  - jmp: `pc_write`=1, `pc_src`=10, retire, go to FETCH.
  - halt: go to HALT without retiring.
  - Undefined opcode: retire, go to FETCH.
- EXEC:
  - Type A: `alu_op`=00, then go to WB.
  - lw/sw: `alu_op`=10, `alu_src`=1, then go to MEM.
  - Branches: `alu_op`=01, `pc_write`=`branch_taken`, `pc_src`=01, retire, go to FETCH.
- MEM: `iord`=1.
  - lw: `mem_read`=1. On `mem_ready`: `mdr_write`=1, go to WB.
  - sw: `mem_write`=1. On `mem_ready`: retire, go to FETCH.
- WB: `reg_write`=1.
  - Type A: `reg_dst`=1, `mem_to_reg`=0.
  - lw: `reg_dst`=0, `mem_to_reg`=1.
  - Retire, then go to FETCH.
- HALT: all strobes 0, `halted`=1. Leaves only on reset.
- ERR: all strobes 0, `halted`=1, `mem_err`=1. Leaves only on reset.
- Retire means `instret` increments by 1 on that clock edge and wraps modulo 2^`CNT_W`.
- Any strobe not named for a state is 0 in that state.

## Timing
- Reset: state=RST, `op_q`=0, `instret`=0, wait counter=0. All outputs are 0 during reset and in the first cycle after release.
- Strobes are decoded combinationally from state and `op_q`.
- `ir_write`, `mdr_write`, FETCH `pc_write` and sw retire also depend on same-cycle `mem_ready`.
- Cycle counts with zero-wait memory:
  - jmp: 2 cycles.
  - Branch: 3 cycles.
  - Type A and sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds 1.
- `mem_ready` is ignored outside FETCH and MEM.
- `branch_taken` is sampled only in the EXEC cycle.
- Reset asserted mid-instruction: immediate return to RST. `instret` is cleared and the partial instruction is not retired.

## Configuration
- `MC_CTRL_TIMEOUT_EN` defined:
  - The wait counter clears on every entry to FETCH or MEM.
  - It increments each cycle `mem_ready`=0 in those states.
  - If `mem_ready`=0 while the counter equals `MEM_TIMEOUT`-1, the next state is ERR.
  - `mem_ready`=1 in that same cycle completes the access normally.
- Not defined: no counter is built and memory waits are unbounded. `mem_err` is tied 0 and ERR is unreachable.

## Test plan
- Zero-wait sequence (`mem_ready`=1), program A, lw, sw, beq (taken), jmp, halt:
  - `instret` goes 0→5.
  - Phase lengths are 4/5/4/3/2 cycles.
  - `halted`=1 after 20 cycles from FETCH entry.
- lw with `mem_ready` low for 3 cycles in FETCH and 2 in MEM:
  - lw takes 10 cycles.
  - `mdr_write` pulses exactly once, in the cycle `mem_ready` rises in MEM.
- blt with `branch_taken`=0 → `pc_write`=0 in EXEC. Repeat with 1 → `pc_write`=1 with `pc_src`=01.
- Opcode 0010 → NOP: DECODE returns to FETCH, `instret` +1, no `reg_write` or memory strobe.
- With `MC_CTRL_TIMEOUT_EN`, `MEM_TIMEOUT`=4:
  - `mem_ready` low 4 cycles in MEM → ERR, `mem_err`=1, `halted`=1.
  - `mem_ready` high on the 4th cycle → normal completion.
- Reset mid-MEM → all outputs 0 immediately, `instret`=0. After release: RST, then FETCH.
- With `CNT_W`=4, 17 jmps → `instret` wraps to 1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit,
// 4-bit-opcode multi-cycle core. Drives datapath strobes from state and
// the latched opcode, waits on a variable-latency memory handshake,
// counts retired instructions and parks the core on HALT or timeout.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   opcode               IR[15:12], valid from DECODE onward
//   mem_ready            memory access completes this cycle
//   branch_taken         ALU compare result, used in EXEC
//   mem_read, mem_write  memory strobes
//   iord                 memory address select (0 = PC, 1 = ALU)
//   ir_write, mdr_write  IR / MDR load enables
//   pc_write, pc_src     PC load enable / source
//   alu_op, alu_src      ALU op class / B-operand select
//   reg_write, reg_dst,
//   mem_to_reg           register-file write controls
//   halted, mem_err      parked / memory timeout flags
//   instret              retired-instruction count (wraps)
//
// Build option: define MC_CTRL_TIMEOUT_EN to bound memory waits at
// MEM_TIMEOUT cycles; otherwise waits are unbounded and mem_err is 0.

module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_RST    = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam logic [3:0] OP_A    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b0100;
  localparam logic [3:0] OP_BGT  = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [2:0] state;
  logic [2:0] nxt;
  logic [3:0] op_q;
  logic       retire;
  logic       tmo;

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] LIM = WW'(MEM_TIMEOUT - 1);

  logic [WW-1:0] wcnt;
  logic          waiting;

  assign waiting = (state == S_FETCH || state == S_MEM) && !mem_ready;
  assign tmo     = waiting && (wcnt == LIM);

  // Any state change clears the counter, which covers every entry
  // into FETCH or MEM; it only advances while stalled in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (nxt != state) begin
      wcnt <= '0;
    end else if (waiting) begin
      wcnt <= wcnt + WW'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt        = state;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    mem_err    = 1'b0;
    case (state)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = S_DECODE;
        end else if (tmo) begin
          nxt = S_ERR;
        end
      end
      // op_q is not loaded until the end of DECODE, so decode
      // from the live IR field in this one state.
      S_DECODE: begin
        case (opcode)
          OP_A, OP_LW, OP_SW,
          OP_BLT, OP_BGT, OP_BEQ: nxt = S_EXEC;
          OP_JMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          OP_HALT: nxt = S_HALT;
          default: begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_A: nxt = S_WB;
          OP_LW, OP_SW: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
            nxt     = S_MEM;
          end
          OP_BLT, OP_BGT, OP_BEQ: begin
            alu_op   = 2'b01;
            pc_write = branch_taken;
            pc_src   = 2'b01;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          default: nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
        end
        if (mem_ready) begin
          if (op_q == OP_LW) begin
            mdr_write = 1'b1;
            nxt       = S_WB;
          end else begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        end else if (tmo) begin
          nxt = S_ERR;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_A);
        mem_to_reg = (op_q == OP_LW);
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      S_ERR: begin
        halted = 1'b1;
`ifdef MC_CTRL_TIMEOUT_EN
        mem_err = 1'b1;
`endif
      end
      default: nxt = S_RST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_RST;
      op_q    <= 4'b0000;
      instret <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q <= opcode;
      end
      if (retire) begin
        instret <= instret + CNT_W'(1);
      end
    end
  end

endmodule
